// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing logic: controller state encoding
// and the bundle of hold/flush/PC-write controls driven into the pipe registers.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } pipe_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_hold;
        logic ifid_flush;
        logic idex_flush;
        logic pipe_freeze;
    } ctrl_t;

    // Normal flow: PC advances, every pipe register loads.
    localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, ifid_hold: 1'b0, ifid_flush: 1'b0,
                                   idex_flush: 1'b0, pipe_freeze: 1'b0};
    // Data memory busy: front end and back end both stand still.
    localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_hold: 1'b1, ifid_flush: 1'b0,
                                      idex_flush: 1'b0, pipe_freeze: 1'b1};
    // Load-use bubble: keep the consumer in ID, inject a NOP into EX.
    localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_hold: 1'b1, ifid_flush: 1'b0,
                                     idex_flush: 1'b1, pipe_freeze: 1'b0};
    // Redirect cycle: kill both wrong-path instructions, PC takes the target.
    localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, ifid_hold: 1'b0, ifid_flush: 1'b1,
                                      idex_flush: 1'b1, pipe_freeze: 1'b0};
    // Extra wrong-path kill cycles: only the fetched instruction is dropped.
    localparam ctrl_t CTRL_KILL_IF = '{pc_write: 1'b1, ifid_hold: 1'b0, ifid_flush: 1'b1,
                                       idex_flush: 1'b0, pipe_freeze: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Performance counter that sticks at all-ones instead of wrapping.
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise step unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller beside the decode stage: load-use bubbles,
// taken-branch kills and memory-wait freezes, plus stall/flush activity counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W             = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] ifid_rs1,
    input  logic [REG_W-1:0] ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0] LS_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);

    pipe_state_e state_q;
    pipe_state_e state_d;
    pipe_state_e ret_q;
    pipe_state_e ret_d;
    pipe_state_e resume_state;
    logic [2:0]  cnt_q;
    logic [2:0]  cnt_d;
    ctrl_t       ctrl;
    logic        branch_evt;
    logic        load_use;
    logic        rs1_hit;
    logic        rs2_hit;

    assign rs1_hit  = ifid_use_rs1 && (ifid_rs1 == idex_rd);
    assign rs2_hit  = ifid_use_rs2 && (ifid_rs2 == idex_rd);
    assign load_use = idex_mem_read && (idex_rd != '0) && (rs1_hit || rs2_hit);

    // Mealy control decode and next-state; a released memory wait behaves exactly like the state it interrupted.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ret_d        = ret_q;
        ctrl         = CTRL_RUN;
        branch_evt   = 1'b0;
        resume_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;

        if (dmem_busy) begin
            ctrl    = CTRL_FREEZE;
            state_d = ST_MEM_WAIT;
            ret_d   = resume_state;
        end else if (branch_taken) begin
            ctrl       = CTRL_BRANCH;
            branch_evt = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                cnt_d   = FL_RELOAD;
            end else begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end else begin
            case (resume_state)
                ST_FLUSH: begin
                    ctrl    = CTRL_KILL_IF;
                    cnt_d   = cnt_q - 3'd1;
                    state_d = (cnt_q > 3'd1) ? ST_FLUSH : ST_RUN;
                end
                ST_LOAD_STALL: begin
                    ctrl    = CTRL_STALL;
                    cnt_d   = cnt_q - 3'd1;
                    state_d = (cnt_q > 3'd1) ? ST_LOAD_STALL : ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                    if (load_use) begin
                        ctrl = CTRL_STALL;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = ST_LOAD_STALL;
                            cnt_d   = LS_RELOAD;
                        end
                    end
                end
            endcase
        end

        if (!reset) begin
            ctrl       = CTRL_RUN;
            branch_evt = 1'b0;
        end
    end

    // Sequencer state: current state, sequence down-counter and resume target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            ret_q   <= ST_RUN;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign ifid_hold   = ctrl.ifid_hold && !ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign pipe_freeze = ctrl.pipe_freeze;
    assign state       = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!ctrl.pc_write),
        .clr   (1'b0),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (branch_evt),
        .clr   (1'b0),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two configurations driven in parallel,
// a remaining-cycles model checked every cycle, and directed literal checks.
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    logic             clk           = 1'b0;
    logic             reset         = 1'b0;
    logic [REG_W-1:0] ifid_rs1      = '0;
    logic [REG_W-1:0] ifid_rs2      = '0;
    logic             ifid_use_rs1  = 1'b0;
    logic             ifid_use_rs2  = 1'b0;
    logic             idex_mem_read = 1'b0;
    logic [REG_W-1:0] idex_rd       = '0;
    logic             branch_taken  = 1'b0;
    logic             dmem_busy     = 1'b0;

    logic             a_pc_write, a_ifid_hold, a_ifid_flush, a_idex_flush, a_pipe_freeze;
    logic [1:0]       a_state;
    logic [CNT_W-1:0] a_stall_cnt, a_flush_cnt;
    logic             b_pc_write, b_ifid_hold, b_ifid_flush, b_idex_flush, b_pipe_freeze;
    logic [1:0]       b_state;
    logic [CNT_W-1:0] b_stall_cnt, b_flush_cnt;

    int checks   = 0;
    int failures = 0;

    // model: index 0 = dut_a (1 stall, 2 flush), index 1 = dut_b (3 stall, 1 flush)
    int   ls_cycles  [2] = '{1, 3};
    int   fl_cycles  [2] = '{2, 1};
    int   stall_left [2] = '{0, 0};
    int   flush_left [2] = '{0, 0};
    bit   was_busy   [2] = '{1'b0, 1'b0};
    int   exp_stall  [2] = '{0, 0};
    int   exp_flush  [2] = '{0, 0};
    logic [4:0] upd_ctrl;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(REG_W), .LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .reset(reset),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .pc_write(a_pc_write), .ifid_hold(a_ifid_hold), .ifid_flush(a_ifid_flush),
        .idex_flush(a_idex_flush), .pipe_freeze(a_pipe_freeze), .state(a_state),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipeline_hazard_ctrl #(.REG_W(REG_W), .LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(1), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .reset(reset),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .pc_write(b_pc_write), .ifid_hold(b_ifid_hold), .ifid_flush(b_ifid_flush),
        .idex_flush(b_idex_flush), .pipe_freeze(b_pipe_freeze), .state(b_state),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    function automatic bit model_load_use();
        bit hit1;
        bit hit2;
        hit1 = ifid_use_rs1 && (ifid_rs1 == idex_rd);
        hit2 = ifid_use_rs2 && (ifid_rs2 == idex_rd);
        return idex_mem_read && (idex_rd != 0) && (hit1 || hit2);
    endfunction

    // {pc_write, ifid_hold, ifid_flush, idex_flush, pipe_freeze}
    function automatic logic [4:0] model_ctrl(int k);
        if (!reset)                                  return 5'b10000;
        if (dmem_busy)                               return 5'b01001;
        if (branch_taken)                            return 5'b10110;
        if (flush_left[k] > 0)                       return 5'b10100;
        if (stall_left[k] > 0 || model_load_use())   return 5'b01010;
        return 5'b10000;
    endfunction

    function automatic logic [1:0] model_state(int k);
        if (was_busy[k])        return 2'd3;
        if (flush_left[k] > 0)  return 2'd2;
        if (stall_left[k] > 0)  return 2'd1;
        return 2'd0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                                 input logic use1, input logic use2, input logic mem_rd,
                                 input logic [REG_W-1:0] rd, input logic bt, input logic busy);
        @(posedge clk);
        #1;
        ifid_rs1      = rs1;
        ifid_rs2      = rs2;
        ifid_use_rs1  = use1;
        ifid_use_rs2  = use2;
        idex_mem_read = mem_rd;
        idex_rd       = rd;
        branch_taken  = bt;
        dmem_busy     = busy;
        #2;
    endtask

    task automatic idle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic loadUse();
        applyStimulus(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        ifid_rs1 = '0; ifid_rs2 = '0; ifid_use_rs1 = 1'b0; ifid_use_rs2 = 1'b0;
        idex_mem_read = 1'b0; idex_rd = '0; branch_taken = 1'b0; dmem_busy = 1'b0;
        #2;
        reset = 1'b0;
        #4;
        reset = 1'b1;
    endtask

    // Model advance: remaining stall/flush cycles, resume across busy, saturating counts.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                stall_left[k] = 0;
                flush_left[k] = 0;
                was_busy[k]   = 1'b0;
                exp_stall[k]  = 0;
                exp_flush[k]  = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                upd_ctrl = model_ctrl(k);
                if (!upd_ctrl[4] && exp_stall[k] < 65535) exp_stall[k]++;
                if (dmem_busy) begin
                    was_busy[k] = 1'b1;
                end else begin
                    was_busy[k] = 1'b0;
                    if (branch_taken) begin
                        if (exp_flush[k] < 65535) exp_flush[k]++;
                        flush_left[k] = fl_cycles[k] - 1;
                        stall_left[k] = 0;
                    end else if (flush_left[k] > 0) begin
                        flush_left[k]--;
                    end else if (stall_left[k] > 0) begin
                        stall_left[k]--;
                    end else if (model_load_use()) begin
                        stall_left[k] = ls_cycles[k] - 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        checkOutput("a.ctrl", 32'({a_pc_write, a_ifid_hold, a_ifid_flush, a_idex_flush, a_pipe_freeze}), 32'(model_ctrl(0)));
        checkOutput("a.state", 32'(a_state), 32'(model_state(0)));
        checkOutput("a.stall_cnt", 32'(a_stall_cnt), exp_stall[0]);
        checkOutput("a.flush_cnt", 32'(a_flush_cnt), exp_flush[0]);
        checkOutput("b.ctrl", 32'({b_pc_write, b_ifid_hold, b_ifid_flush, b_idex_flush, b_pipe_freeze}), 32'(model_ctrl(1)));
        checkOutput("b.state", 32'(b_state), 32'(model_state(1)));
        checkOutput("b.stall_cnt", 32'(b_stall_cnt), exp_stall[1]);
        checkOutput("b.flush_cnt", 32'(b_flush_cnt), exp_flush[1]);
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2;
        checkOutput("reset.pc_write", 32'(a_pc_write), 1);
        checkOutput("reset.state", 32'(a_state), 0);
        checkOutput("reset.stall_cnt", 32'(a_stall_cnt), 0);
        #20;
        reset = 1'b1;

        $display("[TB] load-use, 1 and 3 stall cycles");
        loadUse();
        checkOutput("lu.a.pc_write", 32'(a_pc_write), 0);
        checkOutput("lu.a.ifid_hold", 32'(a_ifid_hold), 1);
        checkOutput("lu.a.idex_flush", 32'(a_idex_flush), 1);
        checkOutput("lu.a.ifid_flush", 32'(a_ifid_flush), 0);
        idle();
        checkOutput("lu.a.resume_pc", 32'(a_pc_write), 1);
        checkOutput("lu.a.resume_state", 32'(a_state), 0);
        checkOutput("lu.a.stall_cnt", 32'(a_stall_cnt), 1);
        checkOutput("lu.b.state", 32'(b_state), 1);
        idle();
        idle();
        checkOutput("lu.b.pc_write", 32'(b_pc_write), 1);
        checkOutput("lu.b.stall_cnt", 32'(b_stall_cnt), 3);

        $display("[TB] no false hazards");
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        checkOutput("nofalse.x0.a", 32'(a_pc_write), 1);
        checkOutput("nofalse.x0.b", 32'(b_pc_write), 1);
        applyStimulus(5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
        checkOutput("nofalse.rs2.a", 32'(a_pc_write), 1);
        checkOutput("nofalse.rs2.b", 32'(b_pc_write), 1);
        applyStimulus(5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0);
        checkOutput("nofalse.noload.a", 32'(a_pc_write), 1);

        $display("[TB] taken branch");
        doReset();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        checkOutput("br.c0.ifid_flush", 32'(a_ifid_flush), 1);
        checkOutput("br.c0.idex_flush", 32'(a_idex_flush), 1);
        checkOutput("br.c0.pc_write", 32'(a_pc_write), 1);
        idle();
        checkOutput("br.c1.ifid_flush", 32'(a_ifid_flush), 1);
        checkOutput("br.c1.idex_flush", 32'(a_idex_flush), 0);
        checkOutput("br.c1.state", 32'(a_state), 2);
        checkOutput("br.b.c1.ifid_flush", 32'(b_ifid_flush), 0);
        idle();
        checkOutput("br.c2.state", 32'(a_state), 0);
        checkOutput("br.c2.ifid_flush", 32'(a_ifid_flush), 0);
        checkOutput("br.flush_cnt", 32'(a_flush_cnt), 1);

        $display("[TB] memory wait inside load stall");
        doReset();
        loadUse();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
            checkOutput("mw.b.pipe_freeze", 32'(b_pipe_freeze), 1);
            checkOutput("mw.b.pc_write", 32'(b_pc_write), 0);
        end
        for (int i = 0; i < 2; i++) begin
            idle();
            checkOutput("mw.b.stall_pc", 32'(b_pc_write), 0);
            checkOutput("mw.b.stall_idex_flush", 32'(b_idex_flush), 1);
            checkOutput("mw.b.stall_freeze", 32'(b_pipe_freeze), 0);
        end
        idle();
        checkOutput("mw.b.run_pc", 32'(b_pc_write), 1);
        checkOutput("mw.b.stall_cnt", 32'(b_stall_cnt), 7);
        checkOutput("mw.a.stall_cnt", 32'(a_stall_cnt), 5);

        $display("[TB] branch and load-use together");
        doReset();
        applyStimulus(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        checkOutput("both.pc_write", 32'(a_pc_write), 1);
        checkOutput("both.ifid_flush", 32'(a_ifid_flush), 1);
        checkOutput("both.ifid_hold", 32'(a_ifid_hold), 0);
        idle();
        checkOutput("both.stall_cnt", 32'(a_stall_cnt), 0);
        checkOutput("both.flush_cnt", 32'(a_flush_cnt), 1);

        $display("[TB] reset during flush");
        doReset();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        idle();
        checkOutput("rstfl.pre_state", 32'(a_state), 2);
        reset = 1'b0;
        #1;
        checkOutput("rstfl.state", 32'(a_state), 0);
        checkOutput("rstfl.flush_cnt", 32'(a_flush_cnt), 0);
        checkOutput("rstfl.pc_write", 32'(a_pc_write), 1);
        checkOutput("rstfl.ifid_flush", 32'(a_ifid_flush), 0);
        #3;
        reset = 1'b1;

        $display("[TB] stall counter saturation");
        doReset();
        for (int i = 0; i < 65534; i++) loadUse();
        loadUse();
        checkOutput("sat.a.preload", 32'(a_stall_cnt), 32'hFFFE);
        loadUse();
        loadUse();
        idle();
        checkOutput("sat.a.max", 32'(a_stall_cnt), 32'hFFFF);
        checkOutput("sat.b.max", 32'(b_stall_cnt), 32'hFFFF);
        idle();
        checkOutput("sat.a.hold", 32'(a_stall_cnt), 32'hFFFF);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It generates the hold, flush and PC-write controls for the IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use hazards, applies taken-branch/jump flushes and freezes the pipe while data memory is busy. It sits beside the decode stage, takes hazard inputs from ID, EX and the data-memory port, and keeps saturating performance counters for stall and flush activity.

## Interface
- REG_W, 5, register-index width
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
- FLUSH_CYCLES, 1, cycles of wrong-path kill after a taken branch (1..7)
- CNT_W, 16, width of performance counters

- clk  in  1  pipeline clock, rising edge
- reset  in  1  reset, asynchronous, active-low
- ifid_rs1, ifid_rs2  in  REG_W  source registers of the instruction in ID
- ifid_use_rs1, ifid_use_rs2  in  1  ID instruction actually reads rs1/rs2
- idex_mem_read  in  1  instruction in EX is a load
- idex_rd  in  REG_W  destination of the instruction in EX
- branch_taken  in  1  EX resolved a taken branch or jump (PC redirect)
- dmem_busy  in  1  data memory has not completed the access in MEM
- pc_write  out  1  1 = PC may update
- ifid_hold  out  1  1 = IF/ID keeps its contents
- ifid_flush  out  1  1 = IF/ID loads zero (NOP)
- idex_flush  out  1  1 = ID/EX loads zero (bubble)
- pipe_freeze  out  1  1 = ID/EX and EX/MEM hold
- state  out  2  current FSM state (debug)
- stall_cnt  out  CNT_W  cycles with pc_write=0, saturating
- flush_cnt  out  CNT_W  taken-branch flush events, saturating

## Operation
- load_use = idex_mem_read & (idex_rd != 0) & ((ifid_use_rs1 & ifid_rs1 == idex_rd) | (ifid_use_rs2 & ifid_rs2 == idex_rd)).
- FSM states are RUN=0, LOAD_STALL=1, FLUSH=2 and MEM_WAIT=3. A 3-bit down-counter `cnt` and a 2-bit resume register `ret` complete the sequential state.
- Outputs are Mealy: combinational from state and current inputs. In every state, dmem_busy has top priority, then branch_taken, then load_use.
- Any state except MEM_WAIT, with dmem_busy=1: pc_write=0, ifid_hold=1, pipe_freeze=1, all flushes 0. The FSM goes to MEM_WAIT, sets ret=current state and keeps cnt unchanged.
- MEM_WAIT: freeze outputs are held while dmem_busy=1. When dmem_busy=0, the outputs are those of state `ret` for that cycle, and the FSM moves to `ret` with cnt as saved.
- RUN, branch_taken: pc_write=1, ifid_flush=1, idex_flush=1, flush_cnt+1. If FLUSH_CYCLES>1, the FSM goes to FLUSH with cnt=FLUSH_CYCLES-1; otherwise it stays in RUN.
- RUN, load_use: pc_write=0, ifid_hold=1, idex_flush=1. If LOAD_STALL_CYCLES>1, the FSM goes to LOAD_STALL with cnt=LOAD_STALL_CYCLES-1; otherwise it stays in RUN.
- RUN, no event: pc_write=1, all other controls 0.
- LOAD_STALL: same outputs as the RUN load-use case, with cnt-1 per cycle. When cnt==1 the FSM returns to RUN.
  - A branch_taken here takes priority and behaves as in RUN; a pending stall is discarded.
- FLUSH: pc_write=1, ifid_flush=1, idex_flush=0, cnt-1 per cycle, RUN when cnt==1.
  - A new branch_taken restarts cnt=FLUSH_CYCLES-1 and increments flush_cnt.
- ifid_hold and ifid_flush are never both 1; flush wins.
- Counters saturate at all-ones and never wrap.

## Timing
- All registers update on the rising edge of clk.
- Hazard response has 0-cycle latency: controls are valid in the same cycle the condition is present.
- A load-use hazard costs exactly LOAD_STALL_CYCLES cycles with pc_write=0.
- The MEM_WAIT duration equals the number of dmem_busy=1 cycles.
- Asynchronous reset (reset=0) sets state=RUN, cnt=0, ret=RUN, stall_cnt=0 and flush_cnt=0.
  - While reset is low, outputs are pc_write=1 and all holds and flushes 0.
  - A reset during LOAD_STALL, FLUSH or MEM_WAIT abandons the sequence immediately, with no resume.

## Structure
- A shared package, pipe_ctrl_pkg, holds the state enum (RUN/LOAD_STALL/FLUSH/MEM_WAIT) and the control-bundle struct {pc_write, ifid_hold, ifid_flush, idex_flush, pipe_freeze}. The IF/ID and ID/EX register wrappers import it as well.
- One sub-module, sat_counter (parameter W, inputs inc/clr), is instantiated twice for stall_cnt and flush_cnt.

## Test plan
- Load-use: lw x5 in EX (idex_mem_read=1, idex_rd=5) with add x6,x5,x1 in ID (ifid_rs1=5, use=1), LOAD_STALL_CYCLES=1.
  - Required: one cycle with pc_write=0, ifid_hold=1, idex_flush=1, then RUN with stall_cnt=1.
- No false hazard: idex_rd=0 with ifid_rs1=0 and a load in EX, or ifid_use_rs2=0 with a matching rs2.
  - Required: pc_write stays 1.
- Taken branch, FLUSH_CYCLES=2: branch_taken pulse.
  - Required: cycle 0 has ifid_flush=1 and idex_flush=1; cycle 1 has ifid_flush=1 only; cycle 2 is RUN; flush_cnt=1.
- Memory wait mid-stall, LOAD_STALL_CYCLES=3: dmem_busy=1 for 4 cycles during the second stall cycle.
  - Required: 4 freeze cycles, then 2 more stall cycles; stall_cnt=7.
- Simultaneous branch_taken and load_use in RUN.
  - Required: flush behaviour only, pc_write=1, stall_cnt unchanged.
- Reset asserted in FLUSH: state=RUN, counters 0 and pc_write=1 immediately, without waiting for a clock.
- Saturation: preload stall_cnt to 0xFFFE and hold load_use for 3 cycles.
  - Required: stall_cnt reaches 0xFFFF and holds.
